i2s_pb_tx: RTL and testbench
============================

// Module: i2s_pb_tx
// PURPOSE
//  Playback-side I2S transmitter. Sits between the sample sources/mixer and the
//  codec DAC pins. Derives bclk and pblrc from mclk (fs = mclk/256). Accepts one
//  stereo sample pair per frame over a valid/ready handshake. Serialises the pair
//  MSB-first onto pbdat in standard I2S format.
// PARAMETERS
//  SAMPLE_BITS    16  width of each channel sample, signed two's complement
//  SLOT_BITS      32  bclk periods per channel slot; frame = 2*SLOT_BITS bclks
//  MCLK_PER_BCLK  4   mclk cycles per bclk; must be an even power of 2
// PORTS
//  mclk          in   1            master clock (~11.29 MHz); all logic on posedge
//  rst           in   1            reset, synchronous, active-high
//  l_sample      in   SAMPLE_BITS  left sample, sampled when sample_valid&&sample_ready
//  r_sample      in   SAMPLE_BITS  right sample, same qualifier
//  sample_valid  in   1            producer offers l/r pair
//  sample_ready  out  1            holding register empty; pair accepted this cycle if valid
//  bclk          out  1            bit clock to codec
//  pblrc         out  1            word select: 0 = left slot, 1 = right slot
//  pbdat         out  1            serial playback data
//  frame_start   out  1            1-mclk pulse when a frame is loaded into the shifter
//  underrun      out  1            1-mclk pulse, coincident with frame_start, if no pair was held
// BEHAVIOUR
//  - Reset: div=0, bit index b=0, bclk=0, pblrc=0, pbdat=0, frame_start=0, underrun=0.
//    Holding register is empty and sample_ready=1. Shifter is cleared to 0.
//  - div counts 0..MCLK_PER_BCLK-1 and wraps. bclk = (div >= MCLK_PER_BCLK/2), registered.
//    bclk falls on the mclk edge where div wraps to 0.
//  - Tick = the mclk cycle with div == MCLK_PER_BCLK-1. All of pblrc, pbdat and b update
//    on tick edges only, so they change together with the bclk falling edge. The codec
//    samples them on bclk rising edges.
//  - b counts 0..2*SLOT_BITS-1 on each tick and wraps. pblrc = (b >= SLOT_BITS).
//  - I2S one-bit delay applies: left MSB is on pbdat at b=1, left LSB at b=SAMPLE_BITS.
//    Right MSB is at b=SLOT_BITS+1. All other bit positions drive 0.
//  - Load: on the tick that enters b=0 with the holding register full:
//    * the holding pair is copied into the shifter;
//    * the holding register is emptied;
//    * frame_start=1 for one cycle.
//  - Underrun: if the holding register is empty at the b=0 load tick:
//    * the shifter is loaded with zeros (silence);
//    * frame_start=1 and underrun=1 for one cycle.
//  - Handshake:
//    * sample_ready = !holding_full, registered.
//    * A pair is captured when valid && ready. ready drops on the next cycle.
//    * ready rises again the cycle after a load.
//    * valid while ready=0 is ignored; the producer must hold the pair.
//  - Simultaneous capture and load tick with the holding register empty:
//    * the load uses the pre-edge state, so underrun fires and zeros are sent;
//    * the captured pair lands in holding for the next frame. There is no bypass.
//  - Sample values are opaque bit patterns. No saturation or truncation is applied;
//    SAMPLE_BITS must be <= SLOT_BITS-1.
//  - Reset mid-frame: every register returns to its reset value on the next edge.
//    A partially sent word is abandoned, and the held pair is discarded.
//  - Frame period = MCLK_PER_BCLK*2*SLOT_BITS mclk cycles (256 at defaults).
// STRUCTURE
//  - Shared package audio_pkg:
//    * SAMPLE_BITS constant;
//    * typedef struct packed { logic signed [15:0] l, r; } stereo_sample_t;
//    * I2S_FRAME_MCLKS = 256.
//  - Sub-module i2s_clkgen holds div, b, bclk, pblrc and the tick/load_tick strobes.
//    The record-side receiver reuses it.
//  - Top level holds the holding register, the handshake, and the 2x SLOT_BITS shifter.
// TESTING
//  1 Reset: hold rst 3 cycles.
//    -> bclk=pblrc=pbdat=0, sample_ready=1, no frame_start; then bclk period 4 mclk.
//  2 Single pair L=16'hA5C3, R=16'h3C5A presented before the first load.
//    -> pbdat bits at b=1..16 = A5C3 MSB-first; b=33..48 = 3C5A; all else 0.
//  3 No valid ever asserted.
//    -> underrun and frame_start pulse together every 256 mclk; pbdat stays 0.
//  4 Backpressure: valid held high with pairs P0, P1.
//    -> P0 accepted; ready low until the load; P1 accepted the cycle after.
//    -> consecutive frames carry P0, then P1.
//  5 Capture on the exact load tick with holding empty.
//    -> underrun=1 and a zero frame; the pair is sent in the following frame.
//  6 rst asserted at b=20 mid-left-word.
//    -> all outputs at reset values next cycle; the next frame starts at b=0 with underrun.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types and constants for the I2S playback/record paths.
// Sample width, slot geometry, frame length and the stereo pair bundle.
package audio_pkg;

  localparam int SAMPLE_BITS       = 16;
  localparam int I2S_SLOT_BITS     = 32;
  localparam int I2S_MCLK_PER_BCLK = 4;
  localparam int I2S_FRAME_MCLKS   = 256;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S timing generator: mclk divider, bit index, bclk/pblrc and strobes.
// In: mclk, rst. Out: bclk, lrc, tick (div at max), load_tick (tick entering b=0).
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int SLOT_BITS     = I2S_SLOT_BITS,
  parameter int MCLK_PER_BCLK = I2S_MCLK_PER_BCLK
) (
  input  logic mclk,
  input  logic rst,
  output logic bclk,
  output logic lrc,
  output logic tick,
  output logic load_tick
);

  localparam int DW = (MCLK_PER_BCLK > 1) ? $clog2(MCLK_PER_BCLK) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);

  localparam logic [DW-1:0] DIV_MAX  = DW'(MCLK_PER_BCLK - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_PER_BCLK / 2);
  localparam logic [BW-1:0] B_MAX    = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] B_SLOT   = BW'(SLOT_BITS);

  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] b_q, b_d;
  logic          bclk_q, bclk_d;
  logic          lrc_q, lrc_d;

  always_comb begin
    tick      = (div_q == DIV_MAX);
    load_tick = tick && (b_q == B_MAX);
    div_d     = tick ? '0 : div_q + 1'b1;
    b_d       = b_q;
    if (tick) begin
      b_d = (b_q == B_MAX) ? '0 : b_q + 1'b1;
    end
    // Registered from next-state so bclk tracks div with no lag.
    bclk_d = (div_d >= DIV_HALF);
    lrc_d  = (b_d >= B_SLOT);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      div_q  <= '0;
      b_q    <= '0;
      bclk_q <= 1'b0;
      lrc_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      b_q    <= b_d;
      bclk_q <= bclk_d;
      lrc_q  <= lrc_d;
    end
  end

  assign bclk = bclk_q;
  assign lrc  = lrc_q;

endmodule

// File: rtl/i2s_pb_tx.sv
// Playback I2S transmitter: holding register, valid/ready intake, frame shifter.
// In: mclk, rst, l/r_sample, sample_valid. Out: sample_ready, bclk, pblrc,
// pbdat, frame_start, underrun.
module i2s_pb_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS   = audio_pkg::SAMPLE_BITS,
  parameter int SLOT_BITS     = I2S_SLOT_BITS,
  parameter int MCLK_PER_BCLK = I2S_MCLK_PER_BCLK
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic [SAMPLE_BITS-1:0] l_sample,
  input  logic [SAMPLE_BITS-1:0] r_sample,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   bclk,
  output logic                   pblrc,
  output logic                   pbdat,
  output logic                   frame_start,
  output logic                   underrun
);

  localparam int FW  = 2 * SLOT_BITS;
  localparam int TOP = FW - 1;

  logic tick, load_tick;

  i2s_clkgen #(
    .SLOT_BITS     (SLOT_BITS),
    .MCLK_PER_BCLK (MCLK_PER_BCLK)
  ) u_clkgen (
    .mclk      (mclk),
    .rst       (rst),
    .bclk      (bclk),
    .lrc       (pblrc),
    .tick      (tick),
    .load_tick (load_tick)
  );

  logic [SAMPLE_BITS-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_BITS-1:0] hold_r_q, hold_r_d;
  logic                   hold_full_q, hold_full_d;
  logic                   ready_q, ready_d;
  logic [FW-1:0]          shift_q, shift_d;
  logic                   pbdat_q, pbdat_d;
  logic                   fs_q, fs_d;
  logic                   ur_q, ur_d;
  logic [FW-1:0]          frame_w;
  logic [FW-1:0]          load_w;
  logic                   capture;

  always_comb begin
    capture     = sample_valid && ready_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    if (load_tick) begin
      hold_full_d = 1'b0;
    end
    // Capture on a load tick lands for the next frame; no bypass.
    if (capture) begin
      hold_full_d = 1'b1;
      hold_l_d    = l_sample;
      hold_r_d    = r_sample;
    end
    ready_d = !hold_full_d;

    // Bit FW-1-b of the frame word goes out at bit index b.
    frame_w = '0;
    frame_w[FW-2 -: SAMPLE_BITS]        = hold_l_q;
    frame_w[SLOT_BITS-2 -: SAMPLE_BITS] = hold_r_q;
    load_w  = hold_full_q ? frame_w : '0;

    shift_d = shift_q;
    pbdat_d = pbdat_q;
    if (load_tick) begin
      pbdat_d = load_w[TOP];
      shift_d = load_w << 1;
    end else if (tick) begin
      pbdat_d = shift_q[TOP];
      shift_d = shift_q << 1;
    end

    fs_d = load_tick;
    ur_d = load_tick && !hold_full_q;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      shift_q     <= '0;
      pbdat_q     <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      shift_q     <= shift_d;
      pbdat_q     <= pbdat_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
    end
  end

  assign sample_ready = ready_q;
  assign pbdat        = pbdat_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;

endmodule

// File: tb/tb_i2s_pb_tx.sv
// Self-checking bench for i2s_pb_tx against a cycle-count reference model.
// Drives pairs through the handshake and checks pins, pulses and serial data.
module tb_i2s_pb_tx;

  logic        mclk = 1'b0;
  logic        rst;
  logic [15:0] l_sample;
  logic [15:0] r_sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        bclk;
  logic        pblrc;
  logic        pbdat;
  logic        frame_start;
  logic        underrun;

  i2s_pb_tx dut (
    .mclk         (mclk),
    .rst          (rst),
    .l_sample     (l_sample),
    .r_sample     (r_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .pblrc        (pblrc),
    .pbdat        (pbdat),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;

  // Model: n = mclk edges since reset release; frame f spans n in [256f, 256f+255].
  int          n;
  bit          held;
  logic [15:0] hl, hr;
  logic [15:0] cl, cr;
  bit          e_fs, e_ur;

  function automatic int cur_b();
    return (n / 4) % 64;
  endfunction

  function automatic logic e_bclk();
    return ((n % 4) >= 2);
  endfunction

  function automatic logic e_lrc();
    return (cur_b() >= 32);
  endfunction

  function automatic logic e_dat();
    int b;
    b = cur_b();
    if (b >= 1 && b <= 16) return cl[16 - b];
    if (b >= 33 && b <= 48) return cr[48 - b];
    return 1'b0;
  endfunction

  task automatic step();
    bit cap;
    cap = sample_valid && !held;
    @(posedge mclk);
    n++;
    e_fs = 1'b0;
    e_ur = 1'b0;
    if (n % 256 == 0) begin
      e_fs = 1'b1;
      e_ur = !held;
      cl   = held ? hl : 16'h0;
      cr   = held ? hr : 16'h0;
      held = 1'b0;
    end
    if (cap) begin
      held = 1'b1;
      hl   = l_sample;
      hr   = r_sample;
    end
    @(negedge mclk);
  endtask

  task automatic do_reset(input int cyc);
    rst          = 1'b1;
    sample_valid = 1'b0;
    l_sample     = '0;
    r_sample     = '0;
    repeat (cyc) @(posedge mclk);
    @(negedge mclk);
    rst  = 1'b0;
    n    = 0;
    held = 1'b0;
    cl   = '0;
    cr   = '0;
    e_fs = 1'b0;
    e_ur = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++;
    if ({bclk, pblrc, pbdat} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pins got %b exp 000", {bclk, pblrc, pbdat});
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", sample_ready);
    end
    checks++;
    if ({frame_start, underrun} !== 2'b00) begin
      errors++;
      $display("FAIL reset_pulses got %b exp 00", {frame_start, underrun});
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (bclk !== e_bclk()) begin
        errors++;
        $display("FAIL bclk_period n=%0d got %b exp %b", n, bclk, e_bclk());
      end
    end
  endtask

  task automatic test_single_pair();
    logic [15:0] gl, gr;
    gl = '0;
    gr = '0;
    do_reset(2);
    sample_valid = 1'b1;
    l_sample     = 16'hA5C3;
    r_sample     = 16'h3C5A;
    step();
    sample_valid = 1'b0;
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_drop got %b exp 0", sample_ready);
    end
    while (n < 512) begin
      step();
      checks++;
      if (pbdat !== e_dat() || frame_start !== e_fs) begin
        errors++;
        $display("FAIL single_bits n=%0d got %b%b exp %b%b",
                 n, pbdat, frame_start, e_dat(), e_fs);
      end
      if (n >= 256 && n % 4 == 0) begin
        if (cur_b() >= 1 && cur_b() <= 16) gl = {gl[14:0], pbdat};
        if (cur_b() >= 33 && cur_b() <= 48) gr = {gr[14:0], pbdat};
      end
    end
    checks++;
    if (gl !== 16'hA5C3) begin
      errors++;
      $display("FAIL single_left got %h exp a5c3", gl);
    end
    checks++;
    if (gr !== 16'h3C5A) begin
      errors++;
      $display("FAIL single_right got %h exp 3c5a", gr);
    end
  endtask

  task automatic test_idle();
    int fs_cnt;
    fs_cnt = 0;
    do_reset(2);
    while (n < 768) begin
      step();
      if (frame_start === 1'b1) fs_cnt++;
      checks++;
      if (frame_start !== e_fs || underrun !== e_fs || pbdat !== 1'b0) begin
        errors++;
        $display("FAIL idle n=%0d got fs=%b ur=%b d=%b exp fs=%b ur=%b d=0",
                 n, frame_start, underrun, pbdat, e_fs, e_fs);
      end
    end
    checks++;
    if (fs_cnt != 3) begin
      errors++;
      $display("FAIL idle_frames got %0d exp 3", fs_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] p0l, p0r, p1l, p1r;
    int k, acc1_n;
    bit acc;
    p0l = 16'($urandom);
    p0r = 16'($urandom);
    p1l = 16'($urandom);
    p1r = 16'($urandom);
    k = 0;
    acc1_n = -1;
    do_reset(2);
    sample_valid = 1'b1;
    l_sample = p0l;
    r_sample = p0r;
    while (n < 800) begin
      acc = sample_valid && sample_ready;
      step();
      if (acc) begin
        k++;
        if (k == 1) begin
          l_sample = p1l;
          r_sample = p1r;
        end else begin
          acc1_n = n;
          sample_valid = 1'b0;
        end
      end
      checks++;
      if (sample_ready !== !held || pbdat !== e_dat() ||
          frame_start !== e_fs || underrun !== e_ur) begin
        errors++;
        $display("FAIL bp n=%0d got rdy=%b d=%b fs=%b ur=%b exp %b %b %b %b",
                 n, sample_ready, pbdat, frame_start, underrun,
                 !held, e_dat(), e_fs, e_ur);
      end
    end
    checks++;
    if (acc1_n != 257) begin
      errors++;
      $display("FAIL bp_p1_accept got n=%0d exp 257", acc1_n);
    end
  endtask

  task automatic test_load_tick_capture();
    logic [15:0] pl, pr, gl;
    pl = 16'($urandom) | 16'h8001;
    pr = 16'($urandom);
    gl = '0;
    do_reset(2);
    while (n < 255) step();
    sample_valid = 1'b1;
    l_sample = pl;
    r_sample = pr;
    step();
    sample_valid = 1'b0;
    checks++;
    if ({frame_start, underrun} !== 2'b11) begin
      errors++;
      $display("FAIL tick_cap_underrun got %b exp 11", {frame_start, underrun});
    end
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL tick_cap_held got rdy=%b exp 0", sample_ready);
    end
    while (n < 768) begin
      step();
      checks++;
      if (pbdat !== e_dat() || underrun !== e_ur) begin
        errors++;
        $display("FAIL tick_cap n=%0d got %b%b exp %b%b",
                 n, pbdat, underrun, e_dat(), e_ur);
      end
      if (n < 512 && pbdat !== 1'b0) begin
        errors++;
        $display("FAIL tick_cap_zero n=%0d got %b exp 0", n, pbdat);
      end
      if (n >= 512 && n % 4 == 0 && cur_b() >= 1 && cur_b() <= 16)
        gl = {gl[14:0], pbdat};
    end
    checks++;
    if (gl !== pl) begin
      errors++;
      $display("FAIL tick_cap_left got %h exp %h", gl, pl);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(2);
    sample_valid = 1'b1;
    l_sample = 16'hFFFF;
    r_sample = 16'hFFFF;
    step();
    sample_valid = 1'b0;
    while (n < 256 + 80) step();
    sample_valid = 1'b1;
    l_sample = 16'h7777;
    step();
    sample_valid = 1'b0;
    rst = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    checks++;
    if ({bclk, pblrc, pbdat, frame_start, underrun, sample_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL mid_reset got %b exp 000001",
               {bclk, pblrc, pbdat, frame_start, underrun, sample_ready});
    end
    rst  = 1'b0;
    n    = 0;
    held = 1'b0;
    cl   = '0;
    cr   = '0;
    while (n < 300) begin
      step();
      checks++;
      if (pbdat !== 1'b0 || underrun !== e_ur || pblrc !== e_lrc()) begin
        errors++;
        $display("FAIL mid_reset_after n=%0d got d=%b ur=%b lrc=%b exp 0 %b %b",
                 n, pbdat, underrun, pblrc, e_ur, e_lrc());
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    do_reset(2);
    while (n < 1300) begin
      acc = sample_valid && sample_ready;
      step();
      if (acc || !sample_valid) begin
        sample_valid = ($urandom_range(0, 99) < 4);
        l_sample = 16'($urandom);
        r_sample = 16'($urandom);
      end
      checks++;
      if (bclk !== e_bclk() || pblrc !== e_lrc() || pbdat !== e_dat() ||
          frame_start !== e_fs || underrun !== e_ur || sample_ready !== !held) begin
        errors++;
        $display("FAIL random n=%0d got %b%b%b%b%b%b exp %b%b%b%b%b%b", n,
                 bclk, pblrc, pbdat, frame_start, underrun, sample_ready,
                 e_bclk(), e_lrc(), e_dat(), e_fs, e_ur, !held);
      end
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_idle();
    test_backpressure();
    test_load_tick_capture();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
